// File: rtl/cache_refill_buffer_if.sv
// cache_refill_buffer_if: connects the cache miss logic and the memory refill port to the refill buffer.
interface cache_refill_buffer_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int BANK_NUM   = 4
);
  localparam int BW = $clog2(BANK_NUM) - 1;
  logic                           miss_cache;
  logic [ADDR_WIDTH-1:0]          addr_miss;
  logic                           busy_rf;
  logic                           req_mem;
  logic [ADDR_WIDTH-1:0]          addr_mem;
  logic [BW-1:0]                  bank_index;
  logic [2*DATA_WIDTH-1:0]        data_mem;
  logic                           valid_mem;
  logic                           line_valid;
  logic [BANK_NUM*DATA_WIDTH-1:0] data_line;
  logic [ADDR_WIDTH-1:0]          addr_line;
  logic                           line_ack;
  modport slave (
    input  miss_cache, addr_miss, data_mem, valid_mem, line_ack,
    output busy_rf, req_mem, addr_mem, bank_index, line_valid, data_line, addr_line
  );
  modport master (
    output miss_cache, addr_miss, data_mem, valid_mem, line_ack,
    input  busy_rf, req_mem, addr_mem, bank_index, line_valid, data_line, addr_line
  );
endinterface

// File: rtl/cache_refill_buffer.sv
// cache_refill_buffer: captures a miss, fetches the line as double-bank beats and holds it until acked.
module cache_refill_buffer #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int BANK_NUM   = 4
) (
  input logic                  clk,
  input logic                  rstn,
  cache_refill_buffer_if.slave bus
);
  localparam int BEATS = BANK_NUM / 2;
  localparam int BW    = $clog2(BANK_NUM) - 1;
  localparam int OFF   = $clog2(BANK_NUM * DATA_WIDTH / 8);
  localparam int LW    = BANK_NUM * DATA_WIDTH;
  localparam int BTW   = 2 * DATA_WIDTH;
  typedef enum logic [1:0] {IDLE, FETCH, READY} state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, addr_aligned;
  logic [BW-1:0]         beat_q, beat_d;
  logic [LW-1:0]         line_q, line_d;
  logic                  last_beat;
  assign addr_aligned = bus.addr_miss & ~{{(ADDR_WIDTH-OFF){1'b0}}, {OFF{1'b1}}};
  assign last_beat    = beat_q == BW'(BEATS - 1);
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    beat_d  = beat_q;
    line_d  = line_q;
    case (state_q)
      IDLE: if (bus.miss_cache) begin
        addr_d  = addr_aligned;
        beat_d  = '0;
        state_d = FETCH;
      end
      FETCH: if (bus.valid_mem) begin
        for (int i = 0; i < BEATS; i++)
          if (beat_q == BW'(i)) line_d[i*BTW +: BTW] = bus.data_mem;
        beat_d  = beat_q + 1'b1;
        state_d = last_beat ? READY : FETCH;
      end
      READY: if (bus.line_ack) begin
        addr_d  = bus.miss_cache ? addr_aligned : addr_q;
        beat_d  = '0;
        state_d = bus.miss_cache ? FETCH : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      beat_q  <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      beat_q  <= beat_d;
      line_q  <= line_d;
    end
  end
  assign bus.busy_rf    = state_q != IDLE;
  assign bus.req_mem    = state_q == FETCH;
  assign bus.line_valid = state_q == READY;
  assign bus.bank_index = beat_q;
  assign bus.addr_mem   = addr_q;
  assign bus.addr_line  = addr_q;
  assign bus.data_line  = line_q;
endmodule

// File: tb/tb_cache_refill_buffer.sv
// tb_cache_refill_buffer: drives a 4-bank and an 8-bank buffer with shared stimulus and checks both
// against a beat-count model every cycle, plus hand-computed literal expectations.
module tb_cache_refill_buffer;
  localparam logic [127:0] B0 = {8{16'hAAAA}};
  localparam logic [127:0] B1 = {8{16'hBBBB}};
  localparam logic [127:0] JK = {8{16'hDEAD}};
  localparam logic [127:0] C3 = {8{16'hCCCC}};
  localparam logic [127:0] D0 = {8{16'h1111}};
  localparam logic [127:0] E0 = {8{16'h5555}};
  localparam logic [127:0] E1 = {8{16'h6666}};
  localparam logic [127:0] E2 = {8{16'h7777}};
  localparam logic [127:0] E3 = {8{16'h8888}};
  logic clk = 0;
  logic rstn = 0;
  always #5 clk = ~clk;
  logic         miss = 0;
  logic [63:0]  addr = '0;
  logic [127:0] dmem = '0;
  logic         vmem = 0;
  logic         ack = 0;
  int tests = 0;
  int fails = 0;
  cache_refill_buffer_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .BANK_NUM(4)) ifa ();
  cache_refill_buffer_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .BANK_NUM(8)) ifb ();
  assign ifa.miss_cache = miss;
  assign ifa.addr_miss  = addr;
  assign ifa.data_mem   = dmem;
  assign ifa.valid_mem  = vmem;
  assign ifa.line_ack   = ack;
  assign ifb.miss_cache = miss;
  assign ifb.addr_miss  = addr;
  assign ifb.data_mem   = dmem;
  assign ifb.valid_mem  = vmem;
  assign ifb.line_ack   = ack;
  cache_refill_buffer #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .BANK_NUM(4)) dut_a (.clk(clk), .rstn(rstn), .bus(ifa));
  cache_refill_buffer #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .BANK_NUM(8)) dut_b (.clk(clk), .rstn(rstn), .bus(ifb));
  // model: k=0 is the 4-bank buffer (2 beats), k=1 the 8-bank buffer (4 beats)
  logic         m_busy [2];
  int           m_cnt  [2];
  logic [63:0]  m_addr [2];
  logic [127:0] m_line [2][4];
  function automatic int nb(int k);
    return k == 1 ? 4 : 2;
  endfunction
  function automatic logic [63:0] align(logic [63:0] a, int k);
    return a & ~((64'd1 << (k == 1 ? 6 : 5)) - 64'd1);
  endfunction
  function automatic logic [511:0] exp_line(int k);
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < nb(k); i++) r[i*128 +: 128] = m_line[k][i];
    return r;
  endfunction
  always @(posedge clk or negedge rstn) begin
    for (int k = 0; k < 2; k++) begin
      if (!rstn) begin
        m_busy[k] <= 1'b0;
        m_cnt[k]  <= 0;
        m_addr[k] <= '0;
        for (int i = 0; i < 4; i++) m_line[k][i] <= '0;
      end else if (!m_busy[k]) begin
        if (miss) begin
          m_busy[k] <= 1'b1;
          m_cnt[k]  <= 0;
          m_addr[k] <= align(addr, k);
        end
      end else if (m_cnt[k] < nb(k)) begin
        if (vmem) begin
          m_line[k][m_cnt[k]] <= dmem;
          m_cnt[k] <= m_cnt[k] + 1;
        end
      end else if (ack) begin
        if (miss) begin
          m_cnt[k]  <= 0;
          m_addr[k] <= align(addr, k);
        end else m_busy[k] <= 1'b0;
      end
    end
  end
  task automatic cmp(string nm, logic [511:0] a, logic [511:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  task automatic chk_dut(int k, logic b, logic r, logic lv, logic [511:0] idx,
                         logic [63:0] am, logic [63:0] al, logic [511:0] dl);
    logic er, elv;
    er  = m_busy[k] && m_cnt[k] < nb(k);
    elv = m_busy[k] && m_cnt[k] == nb(k);
    cmp($sformatf("m%0d_busy", k), 512'(b), 512'(m_busy[k]));
    cmp($sformatf("m%0d_req", k), 512'(r), 512'(er));
    cmp($sformatf("m%0d_line_valid", k), 512'(lv), 512'(elv));
    cmp($sformatf("m%0d_bank_index", k), idx, er ? 512'(m_cnt[k]) : '0);
    cmp($sformatf("m%0d_addr_mem", k), 512'(am), 512'(m_addr[k]));
    cmp($sformatf("m%0d_addr_line", k), 512'(al), 512'(m_addr[k]));
    cmp($sformatf("m%0d_data_line", k), dl, exp_line(k));
  endtask
  always @(negedge clk) begin
    chk_dut(0, ifa.busy_rf, ifa.req_mem, ifa.line_valid, 512'(ifa.bank_index),
            ifa.addr_mem, ifa.addr_line, 512'(ifa.data_line));
    chk_dut(1, ifb.busy_rf, ifb.req_mem, ifb.line_valid, 512'(ifb.bank_index),
            ifb.addr_mem, ifb.addr_line, 512'(ifb.data_line));
  end
  task automatic cycle(logic m, logic [63:0] a, logic v, logic [127:0] d, logic k);
    #1;
    miss = m;
    addr = a;
    vmem = v;
    dmem = d;
    ack  = k;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic all_zero(string tag);
    cmp({tag, "_a_busy"}, 512'(ifa.busy_rf), '0);
    cmp({tag, "_a_req"}, 512'(ifa.req_mem), '0);
    cmp({tag, "_a_lv"}, 512'(ifa.line_valid), '0);
    cmp({tag, "_a_idx"}, 512'(ifa.bank_index), '0);
    cmp({tag, "_a_addr"}, 512'(ifa.addr_mem), '0);
    cmp({tag, "_a_data"}, 512'(ifa.data_line), '0);
    cmp({tag, "_b_busy"}, 512'(ifb.busy_rf), '0);
    cmp({tag, "_b_data"}, 512'(ifb.data_line), '0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    all_zero("lit_reset");
    #1 rstn = 1;
    cycle(1, 64'h1234, 0, '0, 0);
    cmp("lit_miss_busy", 512'(ifa.busy_rf), 512'(1));
    cmp("lit_miss_req", 512'(ifa.req_mem), 512'(1));
    cmp("lit_miss_addr_a", 512'(ifa.addr_mem), 512'(64'h1220));
    cmp("lit_miss_addr_b", 512'(ifb.addr_mem), 512'(64'h1200));
    cmp("lit_miss_idx", 512'(ifa.bank_index), '0);
    cycle(0, '0, 0, '0, 0);
    cycle(1, 64'h9000, 0, '0, 1);
    cmp("lit_fetch_ign_addr", 512'(ifa.addr_mem), 512'(64'h1220));
    cmp("lit_fetch_ign_req", 512'(ifa.req_mem), 512'(1));
    cycle(0, '0, 1, B0, 0);
    cmp("lit_beat0_idx_a", 512'(ifa.bank_index), 512'(1));
    cmp("lit_beat0_idx_b", 512'(ifb.bank_index), 512'(1));
    cycle(0, '0, 0, '0, 0);
    cycle(0, '0, 0, '0, 0);
    cmp("lit_stall_lv", 512'(ifa.line_valid), '0);
    cycle(0, '0, 1, B1, 0);
    cmp("lit_ready_lv", 512'(ifa.line_valid), 512'(1));
    cmp("lit_ready_req", 512'(ifa.req_mem), '0);
    cmp("lit_ready_data", 512'(ifa.data_line), 512'({B1, B0}));
    cmp("lit_ready_b_idx", 512'(ifb.bank_index), 512'(2));
    cycle(0, '0, 1, JK, 0);
    cmp("lit_junk_data_a", 512'(ifa.data_line), 512'({B1, B0}));
    cmp("lit_junk_idx_b", 512'(ifb.bank_index), 512'(3));
    cycle(0, '0, 1, C3, 0);
    cmp("lit_b_ready_lv", 512'(ifb.line_valid), 512'(1));
    cmp("lit_b_ready_data", 512'(ifb.data_line), {C3, JK, B1, B0});
    cycle(1, 64'h4010, 0, '0, 1);
    cmp("lit_remiss_lv", 512'(ifa.line_valid), '0);
    cmp("lit_remiss_req", 512'(ifa.req_mem), 512'(1));
    cmp("lit_remiss_addr_a", 512'(ifa.addr_mem), 512'(64'h4000));
    cmp("lit_remiss_addr_b", 512'(ifb.addr_mem), 512'(64'h4000));
    cmp("lit_remiss_idx", 512'(ifa.bank_index), '0);
    cycle(0, '0, 1, D0, 0);
    cmp("lit_mid_idx", 512'(ifa.bank_index), 512'(1));
    #2 rstn = 0;
    #1 all_zero("lit_async");
    @(negedge clk);
    #1 rstn = 1;
    cycle(1, 64'h1F7, 0, '0, 0);
    cmp("lit_new_addr_a", 512'(ifa.addr_mem), 512'(64'h1E0));
    cmp("lit_new_addr_b", 512'(ifb.addr_mem), 512'(64'h1C0));
    cycle(0, '0, 1, E0, 0);
    cycle(0, '0, 1, E1, 0);
    cmp("lit_b2b_lv", 512'(ifa.line_valid), 512'(1));
    cmp("lit_b2b_data", 512'(ifa.data_line), 512'({E1, E0}));
    cycle(0, '0, 0, '0, 1);
    cmp("lit_ack_idle", 512'(ifa.busy_rf), '0);
    cmp("lit_ack_b_req", 512'(ifb.req_mem), 512'(1));
    cmp("lit_ack_b_idx", 512'(ifb.bank_index), 512'(2));
    cycle(0, '0, 1, E2, 0);
    cmp("lit_idle_ign_busy", 512'(ifa.busy_rf), '0);
    cmp("lit_idle_ign_data", 512'(ifa.data_line), 512'({E1, E0}));
    cmp("lit_b_idx3", 512'(ifb.bank_index), 512'(3));
    cycle(0, '0, 1, E3, 0);
    cmp("lit_b_line", 512'(ifb.data_line), {E3, E2, E1, E0});
    cmp("lit_b_lv", 512'(ifb.line_valid), 512'(1));
    cycle(0, '0, 0, '0, 1);
    cmp("lit_b_idle", 512'(ifb.busy_rf), '0);
    cycle(0, '0, 0, '0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cache_refill_buffer.md
Name: cache_refill_buffer

Overview:
Read-side counterpart of the cache write buffer. On a cache miss it captures the line-aligned miss address, issues a refill request to memory, and accepts the line as BANK_NUM/2 beats of 2*DATA_WIDTH bits. It assembles the full BANK_NUM*DATA_WIDTH line and holds it for the cache until the cache acknowledges it. It sits between the cache miss logic and the memory/bus port.

Parameters:
ADDR_WIDTH, 64, address width in bits
DATA_WIDTH, 64, bank width in bits; one beat is 2*DATA_WIDTH
BANK_NUM, 4, banks per line; power of two, >= 4; beats per line = BANK_NUM/2

Ports:
clk  input  1  clock, rising edge
rstn  input  1  asynchronous active-low reset
miss_cache  input  1  cache miss, refill needed this cycle
addr_miss  input  ADDR_WIDTH  miss address, any byte within the line
busy_rf  output  1  buffer not idle; new misses ignored
req_mem  output  1  refill request to memory, high throughout FETCH
addr_mem  output  ADDR_WIDTH  line-aligned refill address
bank_index  output  $clog2(BANK_NUM)-1  index of the beat currently expected
data_mem  input  2*DATA_WIDTH  refill beat data
valid_mem  input  1  data_mem valid this cycle
line_valid  output  1  assembled line available to the cache
data_line  output  BANK_NUM*DATA_WIDTH  assembled line; beat i occupies bits [(2i+2)*DATA_WIDTH-1 : 2i*DATA_WIDTH]
addr_line  output  ADDR_WIDTH  same value as addr_mem
line_ack  input  1  cache has consumed the line

Behaviour:
- Reset (asynchronous, rstn=0): state IDLE; addr, beat counter, line storage cleared to 0. Outputs busy_rf=0, req_mem=0, line_valid=0, bank_index=0, addr_mem=0, data_line=0. Applies immediately, including mid-FETCH or in READY. The partial line is discarded.
- Line alignment: OFF = $clog2(BANK_NUM*DATA_WIDTH/8). Captured addr = addr_miss with bits [OFF-1:0] cleared (OFF=5 at defaults).
- States: IDLE, FETCH, READY. busy_rf = (state != IDLE). req_mem = (state == FETCH). line_valid = (state == READY). All outputs are registered-state decodes with no combinational input-to-output path.
- IDLE: miss_cache=1 -> capture aligned address, beat=0, go to FETCH next cycle. valid_mem is ignored.
- FETCH: bank_index = beat. On valid_mem=1, store data_mem into beat slot [beat] and increment beat. When valid_mem=1 with beat == BANK_NUM/2-1, go to READY and wrap beat to 0. valid_mem=0 holds state; there is no timeout. miss_cache is ignored.
- READY: data_line and addr_line stay stable. valid_mem is ignored; stray beats must not corrupt the line. line_ack=1 -> IDLE. line_ack=1 together with miss_cache=1 -> capture the new address and go directly to FETCH with beat=0. The old line's storage may then be overwritten beat by beat.
- line_ack outside READY is ignored. Back-to-back beats on consecutive cycles are supported at one beat per cycle.
- Latency at defaults (2 beats): miss at cycle 0 -> req_mem from cycle 1. Beats accepted at cycles 1 and 2 -> line_valid at cycle 3. Minimum miss-to-line latency is BANK_NUM/2+1 cycles.
- data_line bits not yet written in the current fetch hold the previous contents. They are only defined once line_valid=1.

Test Plan:
- Reset values: hold rstn=0 -> every output 0. Release, then miss_cache=1, addr_miss=0x1234 -> cycle+1: busy_rf=1, req_mem=1, addr_mem=0x1220, bank_index=0.
- Refill with stalls: after the miss, valid_mem pulses with a 2-cycle gap, beats 0xAAAA..., 0xBBBB... -> bank_index 0 then 1. line_valid rises the cycle after beat 1, with data_line[127:0]=beat0 and data_line[255:128]=beat1. req_mem falls at the same edge.
- Ignored inputs: in FETCH assert miss_cache with addr 0x9000 -> addr_mem unchanged. In READY assert valid_mem with junk data -> data_line unchanged. line_ack in FETCH -> no state change.
- Ack/re-miss: in READY, line_ack=1 with miss_cache=1 and addr_miss=0x4010 -> next cycle line_valid=0, req_mem=1, addr_mem=0x4000, bank_index=0.
- Async reset mid-fetch: after beat 0, drop rstn between clock edges -> outputs 0 immediately without waiting for a clock edge. After release, a new miss refills cleanly.
- Parameter sweep: BANK_NUM=8 -> 4 beats, bank_index counts 0..3, OFF=6, line_valid after the 4th beat.
